// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART register bus: addresses, command op codes,
// write-enable polarity and the bus-initiator FSM states.
package uart_bus_pkg;

  // Register addresses on the UART slave
  localparam logic [1:0] ADDR_TX  = 2'd0;
  localparam logic [1:0] ADDR_RX  = 2'd1;
  localparam logic [1:0] ADDR_DIV = 2'd2;

  // Bus write-enable polarity: 0 writes, 1 reads
  localparam logic WE_WRITE = 1'b0;
  localparam logic WE_READ  = 1'b1;

  typedef enum logic [1:0] {
    OpWriteTx = 2'b00,
    OpReadRx  = 2'b01,
    OpSetDiv  = 2'b10,
    OpIllegal = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StStrobe  = 3'd2,
    StRelease = 3'd3,
    StResp    = 3'd4
  } state_e;

  // Register address targeted by a legal op
  function automatic logic [1:0] op_to_addr(cmd_op_e op);
    case (op)
      OpReadRx: op_to_addr = ADDR_RX;
      OpSetDiv: op_to_addr = ADDR_DIV;
      default:  op_to_addr = ADDR_TX;
    endcase
  endfunction

endpackage

// File: rtl/uart_wb_master.sv
// Bus initiator for the UART register port. Turns one-byte commands into a
// single strobed bus transaction (setup, wb_clk high until ack, wb_clk low
// until ack releases) and returns a one-cycle response. Every output is a
// flop loaded from the next-state decode.
module uart_wb_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data_out,
  input  logic [7:0] wb_data_in,
  output logic       wb_we,
  output logic       wb_stb,
  output logic       wb_clk,
  input  logic       wb_ack
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(ACK_TIMEOUT);

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  cmd_op_e           op_q, op_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic       accept;
  logic       timer_done;
  logic       resp_err;

  logic       cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [7:0] rsp_data_d;
  logic [1:0] wb_addr_d;
  logic [7:0] wb_data_out_d;
  logic       wb_we_d, wb_stb_d, wb_clk_d;

  assign accept     = cmd_valid & cmd_ready;
  // Current cycle is the last one allowed for the awaited ack edge
  assign timer_done = (timer_q >= TimerLast);

  // State, timer and latched command registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      op_q      <= OpWriteTx;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      op_q      <= op_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state decode, timeout timer and read-data capture
  always_comb begin
    state_d   = state_q;
    resp_err  = 1'b0;
    op_d      = op_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d      = cmd_op_e'(cmd_op);
          rd_data_d = 8'h00;
          if (cmd_op_e'(cmd_op) == OpIllegal) begin
            state_d  = StResp;
            resp_err = 1'b1;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup: state_d = StStrobe;
      StStrobe: begin
        if (wb_ack) begin
          // Leaving STROBE on the first ack means only that ack's data is kept
          state_d = StRelease;
          if (op_q == OpReadRx) rd_data_d = wb_data_in;
        end else if (timer_done) begin
          state_d  = StResp;
          resp_err = 1'b1;
        end
      end
      StRelease: begin
        if (!wb_ack) begin
          state_d = StResp;
        end else if (timer_done) begin
          state_d  = StResp;
          resp_err = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Restart the timer on every state change, saturate otherwise
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != TimerMax) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end
  end

  // Next values of the registered outputs, decoded from the next state
  always_comb begin
    cmd_ready_d   = (state_d == StIdle);
    rsp_valid_d   = (state_d == StResp);
    rsp_err_d     = (state_d == StResp) && resp_err;
    rsp_data_d    = 8'h00;
    wb_stb_d      = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StRelease);
    wb_clk_d      = (state_d == StStrobe);
    wb_addr_d     = wb_addr;
    wb_data_out_d = wb_data_out;
    wb_we_d       = wb_we;
    if ((state_d == StResp) && !resp_err && (op_q == OpReadRx)) begin
      rsp_data_d = rd_data_q;
    end
    if ((state_q == StIdle) && (state_d == StSetup)) begin
      wb_addr_d     = op_to_addr(cmd_op_e'(cmd_op));
      wb_we_d       = (cmd_op_e'(cmd_op) == OpReadRx) ? WE_READ : WE_WRITE;
      wb_data_out_d = (cmd_op_e'(cmd_op) == OpReadRx) ? 8'h00 : cmd_data;
    end else if (!wb_stb_d) begin
      // Bus idles at zero outside a transaction
      wb_addr_d     = 2'd0;
      wb_we_d       = WE_WRITE;
      wb_data_out_d = 8'h00;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_err     <= 1'b0;
      wb_addr     <= 2'd0;
      wb_data_out <= 8'h00;
      wb_we       <= 1'b0;
      wb_stb      <= 1'b0;
      wb_clk      <= 1'b0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      wb_addr     <= wb_addr_d;
      wb_data_out <= wb_data_out_d;
      wb_we       <= wb_we_d;
      wb_stb      <= wb_stb_d;
      wb_clk      <= wb_clk_d;
    end
  end

endmodule
